// File: rtl/sc_fifo_flagged_pkg.sv
// Shared types and helpers for the flagged single-clock FIFO.
`include "fifo_defs.vh"
package sc_fifo_flagged_pkg;
  localparam int MODE_SHOWAHEAD = `FIFO_SHOWAHEAD;
  localparam int MODE_REGOUT    = `FIFO_REGOUT;

  typedef struct packed {
    logic ovf;
    logic unf;
  } err_flags_t;

  function automatic bit levels_legal(int ae, int af, int n);
    return (ae >= 0) && (ae < af) && (af <= n);
  endfunction
endpackage

// File: rtl/fifo_defs.vh
// Mode constants and width macros shared by the FIFO family (sc, dc, multi-channel).
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH
`define FIFO_SHOWAHEAD 1
`define FIFO_REGOUT 0
`define FIFO_USEDW_W(log2n) ((log2n) + 1)
`endif

// File: rtl/sc_fifo_ram.sv
// Simple dual-port RAM: synchronous write, async read or registered read (SYNC_RD).
module sc_fifo_ram #(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter bit SYNC_RD = 1'b0
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem_q [1 << AW];

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  if (SYNC_RD) begin : g_sync_rd
    logic [DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_clr)     rd_data_d = '0;
      else if (rd_en) rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clock or posedge aclr) begin
      if (aclr) rd_data_q <= '0;
      else      rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
  end else begin : g_async_rd
    logic unused_rd_ctl;
    assign unused_rd_ctl = ^{aclr, rd_en, rd_clr};
    assign rd_data = mem_q[rd_addr];
  end
endmodule

// File: rtl/sc_fifo_flagged.sv
// Single-clock FIFO with show-ahead/registered read, almost flags and sticky error flags.
`include "fifo_defs.vh"
module sc_fifo_flagged
  import sc_fifo_flagged_pkg::*;
#(
  parameter int LOG2N      = 6,
  parameter int DATA_WIDTH = 32,
  parameter int SHOWAHEAD  = MODE_SHOWAHEAD,
  parameter int AF_LEVEL   = (1 << LOG2N) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clock,
  input  logic                    aclr,
  input  logic                    sclr,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic                    wrreq,
  input  logic                    rdreq,
  output logic [DATA_WIDTH-1:0]   q,
  output logic [LOG2N:0]          usedw,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    err_clr
);
  localparam int N  = 1 << LOG2N;
  localparam int UW = `FIFO_USEDW_W(LOG2N);

  logic [UW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  err_flags_t    err_q, err_d;
  logic          wr_acc, rd_acc;

  if (!levels_legal(AE_LEVEL, AF_LEVEL, N)) begin : g_bad_levels
    $error("sc_fifo_flagged: require 0 <= AE_LEVEL < AF_LEVEL <= N");
  end

  // Extra pointer bit makes wr-rd cover the full 0..N range without a separate counter.
  assign usedw        = wr_ptr_q - rd_ptr_q;
  assign full         = (usedw == UW'(N));
  assign empty        = (usedw == '0);
  assign almost_full  = (usedw >= UW'(AF_LEVEL));
  assign almost_empty = (usedw <= UW'(AE_LEVEL));
  assign overflow     = err_q.ovf;
  assign underflow    = err_q.unf;

  assign wr_acc = wrreq && !full  && !sclr;
  assign rd_acc = rdreq && !empty && !sclr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      err_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + UW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + UW'(1);
      // A fresh error in the same cycle as err_clr keeps the flag set.
      err_d.ovf = (wrreq && full)  || (err_q.ovf && !err_clr);
      err_d.unf = (rdreq && empty) || (err_q.unf && !err_clr);
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  sc_fifo_ram #(
    .AW      (LOG2N),
    .DW      (DATA_WIDTH),
    .SYNC_RD (SHOWAHEAD == MODE_REGOUT)
  ) u_ram (
    .clock   (clock),
    .aclr    (aclr),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[LOG2N-1:0]),
    .wr_data (data),
    .rd_en   (rd_acc),
    .rd_clr  (sclr),
    .rd_addr (rd_ptr_q[LOG2N-1:0]),
    .rd_data (q)
  );
endmodule

// File: tb/tb_sc_fifo_flagged.sv
// Bench for sc_fifo_flagged: registered-read and show-ahead instances driven in lockstep.
module tb_sc_fifo_flagged;
  logic       clock = 1'b0;
  logic       aclr, sclr, wrreq, rdreq, err_clr;
  logic [7:0] data;
  logic [7:0] q0, q1;
  logic [2:0] uw0, uw1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;

  always #5 clock = ~clock;

  sc_fifo_flagged #(.LOG2N(2), .DATA_WIDTH(8), .SHOWAHEAD(0), .AF_LEVEL(3), .AE_LEVEL(1)) u0 (
    .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q0), .usedw(uw0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .overflow(ovf0), .underflow(unf0), .err_clr(err_clr));

  sc_fifo_flagged #(.LOG2N(2), .DATA_WIDTH(8), .SHOWAHEAD(1), .AF_LEVEL(3), .AE_LEVEL(1)) u1 (
    .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q1), .usedw(uw1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .overflow(ovf1), .underflow(unf1), .err_clr(err_clr));

  wire [5:0] f0 = {full0, empty0, af0, ae0, ovf0, unf0};
  wire [5:0] f1 = {full1, empty1, af1, ae1, ovf1, unf1};

  logic [7:0] sb[$];
  bit         ovf_m, unf_m, did_pop;
  logic [7:0] q0_m, popped, q1_pre;
  int         n_cmp = 0, n_bad = 0;

  function automatic logic [5:0] exp_flags();
    int s = sb.size();
    return {s == 4, s == 0, s >= 3, s <= 1, ovf_m, unf_m};
  endfunction

  function automatic logic [2:0] exp_uw();
    return 3'(sb.size());
  endfunction

  // One clock of stimulus; the model advances on pre-edge state, q1 is sampled before the edge.
  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit sc = 0, input bit ec = 0);
    bit fm, em, wa, ra;
    wrreq = wr; data = d; rdreq = rd; sclr = sc; err_clr = ec;
    @(negedge clock);
    q1_pre = q1;
    fm = (sb.size() == 4); em = (sb.size() == 0); did_pop = 0;
    if (sc) begin
      sb.delete(); ovf_m = 0; unf_m = 0; q0_m = 8'h00;
    end else begin
      ra = rd && !em; wa = wr && !fm;
      if (ra) begin popped = sb.pop_front(); did_pop = 1; q0_m = popped; end
      if (wa) sb.push_back(d);
      ovf_m = (wr && fm) || (ovf_m && !ec);
      unf_m = (rd && em) || (unf_m && !ec);
    end
    @(posedge clock); #1;
    wrreq = 0; rdreq = 0; sclr = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    wrreq = 0; rdreq = 0; sclr = 0; err_clr = 0; data = 8'h00; aclr = 1'b1;
    sb.delete(); ovf_m = 0; unf_m = 0; q0_m = 8'h00;
    @(posedge clock); #1;
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL reset_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL reset_flags got %b/%b want %b", f0, f1, exp_flags()); end
    n_cmp++; if (q0 !== 8'h00) begin n_bad++; $display("FAIL reset_q0 got %h want 00", q0); end
    @(negedge clock); aclr = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'((i + 1) * 17), 0);
      n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL fill_usedw[%0d] got %h/%h want %h", i, uw0, uw1, exp_uw()); end
      n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL fill_flags[%0d] got %b/%b want %b", i, f0, f1, exp_flags()); end
    end
  endtask

  task automatic test_overflow_drain();
    cyc(1, 8'h55, 0);
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL ovf_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL ovf_flags got %b/%b want %b", f0, f1, exp_flags()); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1);
      n_cmp++; if (q1_pre !== popped) begin n_bad++; $display("FAIL drain_q1[%0d] got %h want %h", i, q1_pre, popped); end
      n_cmp++; if (q0 !== popped) begin n_bad++; $display("FAIL drain_q0[%0d] got %h want %h", i, q0, popped); end
      n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL drain_flags[%0d] got %b/%b want %b", i, f0, f1, exp_flags()); end
    end
  endtask

  task automatic test_simultaneous();
    cyc(0, 8'h00, 0, 0, 1);
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL errclr_flags got %b/%b want %b", f0, f1, exp_flags()); end
    for (int i = 0; i < 4; i++) cyc(1, 8'((i + 1) * 17), 0);
    cyc(1, 8'h66, 1);
    n_cmp++; if (q1_pre !== popped) begin n_bad++; $display("FAIL fullrw_q1 got %h want %h", q1_pre, popped); end
    n_cmp++; if (q0 !== popped) begin n_bad++; $display("FAIL fullrw_q0 got %h want %h", q0, popped); end
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL fullrw_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL fullrw_flags got %b/%b want %b", f0, f1, exp_flags()); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 1);
      n_cmp++; if ({q1_pre, q0} !== {2{popped}}) begin n_bad++; $display("FAIL fullrw_drain[%0d] got %h/%h want %h", i, q1_pre, q0, popped); end
    end
    cyc(1, 8'h77, 1);
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL emptyrw_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL emptyrw_flags got %b/%b want %b", f0, f1, exp_flags()); end
    cyc(0, 8'h00, 1);
    n_cmp++; if ({q1_pre, q0} !== {2{popped}} || !did_pop) begin n_bad++; $display("FAIL emptyrw_read got %h/%h want %h", q1_pre, q0, popped); end
  endtask

  task automatic test_wrap();
    cyc(1, 8'hA0, 0);
    cyc(1, 8'hA1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(8'hA2 + i), 1);
      n_cmp++; if ({q1_pre, q0} !== {2{popped}}) begin n_bad++; $display("FAIL wrap_data[%0d] got %h/%h want %h", i, q1_pre, q0, popped); end
      n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL wrap_usedw[%0d] got %h/%h want %h", i, uw0, uw1, exp_uw()); end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 8'h00, 1);
      n_cmp++; if ({q1_pre, q0} !== {2{popped}}) begin n_bad++; $display("FAIL wrap_drain[%0d] got %h/%h want %h", i, q1_pre, q0, popped); end
    end
  endtask

  task automatic test_sclr_errclr();
    cyc(0, 8'h00, 1);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hB0 + i), 0);
    cyc(0, 8'h00, 1);
    cyc(1, 8'hB3, 0);
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL presclr_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
    cyc(1, 8'h99, 0, 1);
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL sclr_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL sclr_flags got %b/%b want %b", f0, f1, exp_flags()); end
    n_cmp++; if (q0 !== q0_m) begin n_bad++; $display("FAIL sclr_q0 got %h want %h", q0, q0_m); end
    cyc(0, 8'h00, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i), 0);
    cyc(1, 8'hAB, 0);
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL botherr_flags got %b/%b want %b", f0, f1, exp_flags()); end
    cyc(1, 8'hCD, 0, 0, 1);
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL errclr_newerr got %b/%b want %b", f0, f1, exp_flags()); end
    cyc(0, 8'h00, 0, 0, 1);
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL errclr_only_flags got %b/%b want %b", f0, f1, exp_flags()); end
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL errclr_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
  endtask

  task automatic test_aclr_midburst();
    cyc(1, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hD0 + i), 0);
    cyc(0, 8'h00, 1);
    n_cmp++; if (q0 !== popped) begin n_bad++; $display("FAIL preaclr_q0 got %h want %h", q0, popped); end
    wrreq = 1; data = 8'hEE;
    #2 aclr = 1'b1;
    sb.delete(); ovf_m = 0; unf_m = 0; q0_m = 8'h00;
    #1;
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL aclr_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
    n_cmp++; if ({f0, f1} !== {2{exp_flags()}}) begin n_bad++; $display("FAIL aclr_flags got %b/%b want %b", f0, f1, exp_flags()); end
    n_cmp++; if (q0 !== q0_m) begin n_bad++; $display("FAIL aclr_q0 got %h want %h", q0, q0_m); end
    #2 aclr = 1'b0; wrreq = 0;
    cyc(0, 8'h00, 0);
    n_cmp++; if ({uw0, uw1} !== {2{exp_uw()}}) begin n_bad++; $display("FAIL postaclr_usedw got %h/%h want %h", uw0, uw1, exp_uw()); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_simultaneous();
    test_wrap();
    test_sclr_errclr();
    test_aclr_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
